// File: rtl/mem_stage_if.sv
// Byte-wide RAM port shared with the IF/MEM arbiter.
// The stage is the master and issues one byte per granted cycle.
interface mem_stage_if #(parameter int ADDR_W = 32);
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_a_o;
  logic [7:0]        mem_dout_o;
  logic              mem_wr_o;
  logic              mem_gnt_i;
  logic [7:0]        mem_din_i;

  modport master (
    output mem_req_o, mem_a_o, mem_dout_o, mem_wr_o,
    input  mem_gnt_i, mem_din_i
  );

  modport slave (
    input  mem_req_o, mem_a_o, mem_dout_o, mem_wr_o,
    output mem_gnt_i, mem_din_i
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU results through, and serialises loads/stores
// onto the 8-bit RAM port while holding the pipeline with a stall request.
module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  input  logic              stall_i,
  mem_stage_if.master       ram,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              stall_req_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_LAST, S_DONE} state_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    is_mem_op = (op >= OP_LB) && (op <= OP_SW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] last_idx(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: last_idx = 2'd0;
      OP_LH, OP_LHU, OP_SH: last_idx = 2'd1;
      OP_LW, OP_SW:         last_idx = 2'd3;
      default:              last_idx = 2'd0;
    endcase
  endfunction

  function automatic logic [7:0] store_byte(input logic [31:0] data, input logic [1:0] idx);
    case (idx)
      2'd0:    store_byte = data[7:0];
      2'd1:    store_byte = data[15:8];
      2'd2:    store_byte = data[23:16];
      2'd3:    store_byte = data[31:24];
      default: store_byte = 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [31:0] w);
    case (op)
      OP_LB:   load_ext = {{24{w[7]}}, w[7:0]};
      OP_LH:   load_ext = {{16{w[15]}}, w[15:0]};
      OP_LBU:  load_ext = {24'h000000, w[7:0]};
      OP_LHU:  load_ext = {16'h0000, w[15:0]};
      default: load_ext = w;
    endcase
  endfunction

  state_t            state_r;
  logic [3:0]        op_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       sdata_r;
  logic [4:0]        wd_r;
  logic              wreg_r;
  logic [31:0]       wdata_r;
  logic [1:0]        cnt_r;
  logic [1:0]        cnt_prev_r;
  logic              rd_pending_r;
  logic [3:0][7:0]   ld_buf_r;
  logic              issue_s;

  assign issue_s = (state_r == S_BUSY) && ram.mem_gnt_i && !rst;

  // Access sequencer, byte counter and load-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      op_r         <= 4'd0;
      addr_r       <= {ADDR_W{1'b0}};
      sdata_r      <= 32'h0000_0000;
      wd_r         <= 5'd0;
      wreg_r       <= 1'b0;
      wdata_r      <= 32'h0000_0000;
      cnt_r        <= 2'd0;
      cnt_prev_r   <= 2'd0;
      rd_pending_r <= 1'b0;
      ld_buf_r     <= 32'h0000_0000;
    end else begin
      // Read data arrives one cycle after its address, whatever state we are in by then.
      rd_pending_r <= issue_s && !is_store(op_r);
      if (issue_s) cnt_prev_r <= cnt_r;
      if (rd_pending_r) ld_buf_r[cnt_prev_r] <= ram.mem_din_i;
      case (state_r)
        S_IDLE: begin
          if (is_mem_op(mem_op_i)) begin
            op_r    <= mem_op_i;
            addr_r  <= mem_addr_i;
            sdata_r <= mem_wdata_i;
            wd_r    <= wd_i;
            wreg_r  <= wreg_i;
            wdata_r <= wdata_i;
            cnt_r   <= 2'd0;
            state_r <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (ram.mem_gnt_i) begin
            if (cnt_r == last_idx(op_r)) begin
              state_r <= is_store(op_r) ? S_DONE : S_LAST;
            end else begin
              cnt_r <= cnt_r + 2'd1;
            end
          end
        end
        S_LAST: state_r <= S_DONE;
        // Hold the result while the rest of the pipeline is stalled so the
        // instruction still sitting in EX/MEM is not executed twice.
        S_DONE: if (!stall_i) state_r <= S_IDLE;
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // RAM port drive and writeback/stall outputs.
  always_comb begin
    ram.mem_req_o  = 1'b0;
    ram.mem_a_o    = {ADDR_W{1'b0}};
    ram.mem_dout_o = 8'h00;
    ram.mem_wr_o   = 1'b0;
    wd_o           = 5'd0;
    wreg_o         = 1'b0;
    wdata_o        = 32'h0000_0000;
    stall_req_o    = 1'b0;
    if (!rst) begin
      case (state_r)
        S_IDLE: begin
          wd_o    = wd_i;
          wdata_o = wdata_i;
          if (is_mem_op(mem_op_i)) begin
            stall_req_o = 1'b1;
            wreg_o      = 1'b0;
          end else begin
            stall_req_o = 1'b0;
            wreg_o      = wreg_i;
          end
        end
        S_BUSY: begin
          ram.mem_req_o = 1'b1;
          stall_req_o   = 1'b1;
          wd_o          = wd_r;
          wdata_o       = wdata_r;
          if (ram.mem_gnt_i) begin
            ram.mem_a_o    = addr_r + ADDR_W'(cnt_r);
            ram.mem_wr_o   = is_store(op_r);
            ram.mem_dout_o = is_store(op_r) ? store_byte(sdata_r, cnt_r) : 8'h00;
          end else begin
            ram.mem_wr_o = 1'b0;
          end
        end
        S_LAST: begin
          stall_req_o = 1'b1;
          wd_o        = wd_r;
          wdata_o     = wdata_r;
        end
        S_DONE: begin
          wd_o = wd_r;
          if (is_store(op_r)) begin
            wreg_o  = 1'b0;
            wdata_o = wdata_r;
          end else begin
            wreg_o  = wreg_r;
            wdata_o = load_ext(op_r, ld_buf_r);
          end
        end
        default: stall_req_o = 1'b0;
      endcase
    end else begin
      stall_req_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through table, load/store table against a
// byte RAM model, plus hand sequences for write ordering, DONE hold and mid-access reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        stall_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o;

  mem_stage_if #(.ADDR_W(32)) ram_if ();

  mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .stall_i(stall_i), .ram(ram_if),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_req_o(stall_req_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
    logic [31:0] cyc;
  } wr_rec_t;

  logic [7:0]  mem [0:1023] = '{default: 8'h00};
  wr_rec_t     wlog [$];
  logic [31:0] cyc = 32'd0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // RAM model: one byte per granted cycle, read data valid the next cycle.
  always @(posedge clk) begin
    if (rst) begin
      mem[10'h200] <= 8'h80;
      mem[10'h201] <= 8'hFF;
    end
    if (ram_if.mem_req_o && ram_if.mem_gnt_i) begin
      if (ram_if.mem_wr_o) begin
        mem[ram_if.mem_a_o[9:0]] <= ram_if.mem_dout_o;
        wlog.push_back({ram_if.mem_a_o, ram_if.mem_dout_o, cyc});
      end else begin
        ram_if.mem_din_i <= mem[ram_if.mem_a_o[9:0]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [4:0]  exp_wd;
    logic        exp_wreg;
    logic [31:0] exp_wdata;
  } nop_vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] alu;
    logic [31:0] gnt_low;
    int          exp_done;
    logic [31:0] exp_wdata;
    logic        exp_wreg;
  } mem_vec_t;

  nop_vec_t nops [5];
  mem_vec_t vecs [14];

  task automatic set_nop(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    mem_op_i = 4'd0; wd_i = wd; wreg_i = wreg; wdata_i = wdata;
    mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
  endtask

  // Entered and left just after a rising edge with the DUT idle.
  task automatic run_op(input mem_vec_t v, input logic [4:0] wd, input int hold,
                        input string tag, output logic [31:0] c0);
    int done_c;
    mem_op_i = v.op; mem_addr_i = v.addr; mem_wdata_i = v.sdata;
    wd_i = wd; wreg_i = 1'b1; wdata_i = v.alu;
    ram_if.mem_gnt_i = !v.gnt_low[0];
    c0 = cyc;
    @(negedge clk);
    chk({tag, "/stall_c0"}, 32'(stall_req_o), 32'd1);
    chk({tag, "/wreg_c0"}, 32'(wreg_o), 32'd0);
    done_c = -1;
    for (int c = 1; c <= 24 && done_c < 0; c++) begin
      @(posedge clk); #1;
      ram_if.mem_gnt_i = !v.gnt_low[c];
      @(negedge clk);
      if (!stall_req_o) done_c = c;
    end
    chk({tag, "/done_cycle"}, 32'(done_c), 32'(v.exp_done));
    chk({tag, "/wdata"}, wdata_o, v.exp_wdata);
    chk({tag, "/wreg"}, 32'(wreg_o), 32'(v.exp_wreg));
    chk({tag, "/wd"}, 32'(wd_o), 32'(wd));
    chk({tag, "/req_done"}, 32'(ram_if.mem_req_o), 32'd0);
    if (hold > 0) begin
      stall_i = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        @(negedge clk);
        chk({tag, "/hold_wdata"}, wdata_o, v.exp_wdata);
        chk({tag, "/hold_wreg"}, 32'(wreg_o), 32'(v.exp_wreg));
        chk({tag, "/hold_req"}, 32'(ram_if.mem_req_o), 32'd0);
        chk({tag, "/hold_stall"}, 32'(stall_req_o), 32'd0);
      end
      stall_i = 1'b0;
    end
    @(posedge clk); #1;
    set_nop(5'd5, 1'b1, 32'h0000_1234);
    ram_if.mem_gnt_i = 1'b1;
    @(negedge clk);
    chk({tag, "/idle_wdata"}, wdata_o, 32'h0000_1234);
    chk({tag, "/idle_stall"}, 32'(stall_req_o), 32'd0);
    chk({tag, "/idle_req"}, 32'(ram_if.mem_req_o), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] c0;
    logic [7:0]  sw_bytes [4];
    sw_bytes = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};

    nops[0] = '{4'd0,  5'd5,  1'b1, 32'h0000_1234, 5'd5,  1'b1, 32'h0000_1234};
    nops[1] = '{4'd0,  5'd31, 1'b0, 32'hFFFF_FFFF, 5'd31, 1'b0, 32'hFFFF_FFFF};
    nops[2] = '{4'd9,  5'd3,  1'b1, 32'hDEAD_BEEF, 5'd3,  1'b1, 32'hDEAD_BEEF};
    nops[3] = '{4'd15, 5'd16, 1'b1, 32'h0000_0000, 5'd16, 1'b1, 32'h0000_0000};
    nops[4] = '{4'd12, 5'd1,  1'b0, 32'h8000_0001, 5'd1,  1'b0, 32'h8000_0001};

    //            op     addr           sdata          alu            gnt_low  done exp_wdata      wreg
    vecs[0]  = '{4'd3, 32'h0000_0100, 32'h0,         32'h0,         32'h0,   6, 32'hAABB_CCDD, 1'b1};
    vecs[1]  = '{4'd2, 32'h0000_0200, 32'h0,         32'h0,         32'h0,   4, 32'hFFFF_FF80, 1'b1};
    vecs[2]  = '{4'd5, 32'h0000_0200, 32'h0,         32'h0,         32'h0,   4, 32'h0000_FF80, 1'b1};
    vecs[3]  = '{4'd1, 32'h0000_0200, 32'h0,         32'h0,         32'h0,   3, 32'hFFFF_FF80, 1'b1};
    vecs[4]  = '{4'd4, 32'h0000_0201, 32'h0,         32'h0,         32'h0,   3, 32'h0000_00FF, 1'b1};
    vecs[5]  = '{4'd6, 32'h0000_0300, 32'h1234_5678, 32'hA5A5_A5A5, 32'h0,   2, 32'hA5A5_A5A5, 1'b0};
    vecs[6]  = '{4'd7, 32'h0000_0302, 32'h0000_9ABC, 32'h0000_005A, 32'h0,   3, 32'h0000_005A, 1'b0};
    vecs[7]  = '{4'd3, 32'h0000_0300, 32'h0,         32'h0,         32'h0,   6, 32'h9ABC_0078, 1'b1};
    vecs[8]  = '{4'd3, 32'h0000_0100, 32'h0,         32'h0,         32'hC,   8, 32'hAABB_CCDD, 1'b1};
    vecs[9]  = '{4'd5, 32'h0000_0101, 32'h0,         32'h0,         32'h2,   5, 32'h0000_BBCC, 1'b1};
    vecs[10] = '{4'd8, 32'hFFFF_FFFE, 32'h1122_3344, 32'h0000_0077, 32'h0,   5, 32'h0000_0077, 1'b0};
    vecs[11] = '{4'd3, 32'hFFFF_FFFE, 32'h0,         32'h0,         32'h0,   6, 32'h1122_3344, 1'b1};
    vecs[12] = '{4'd2, 32'h0000_0102, 32'h0,         32'h0,         32'h0,   4, 32'hFFFF_AABB, 1'b1};
    vecs[13] = '{4'd1, 32'h0000_0103, 32'h0,         32'h0,         32'h2,   4, 32'hFFFF_FFAA, 1'b1};

    // Reset with a store presented: everything must stay quiet.
    rst = 1'b1; stall_i = 1'b0; ram_if.mem_gnt_i = 1'b1;
    mem_op_i = 4'd8; mem_addr_i = 32'h40; mem_wdata_i = 32'hFFFF_FFFF;
    wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'h0000_FFFF;
    @(negedge clk);
    chk("rst/stall", 32'(stall_req_o), 32'd0);
    chk("rst/req", 32'(ram_if.mem_req_o), 32'd0);
    chk("rst/wr", 32'(ram_if.mem_wr_o), 32'd0);
    chk("rst/wd", 32'(wd_o), 32'd0);
    chk("rst/wreg", 32'(wreg_o), 32'd0);
    chk("rst/wdata", wdata_o, 32'd0);
    @(posedge clk); #1;
    set_nop(5'd0, 1'b0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Pass-through table.
    for (int i = 0; i < 5; i++) begin
      mem_op_i = nops[i].op; wd_i = nops[i].wd; wreg_i = nops[i].wreg; wdata_i = nops[i].wdata;
      @(negedge clk);
      chk($sformatf("nop%0d/wd", i), 32'(wd_o), 32'(nops[i].exp_wd));
      chk($sformatf("nop%0d/wreg", i), 32'(wreg_o), 32'(nops[i].exp_wreg));
      chk($sformatf("nop%0d/wdata", i), wdata_o, nops[i].exp_wdata);
      chk($sformatf("nop%0d/stall", i), 32'(stall_req_o), 32'd0);
      chk($sformatf("nop%0d/req", i), 32'(ram_if.mem_req_o), 32'd0);
      @(posedge clk); #1;
    end

    // SW byte order, addresses and issue cycles.
    wlog.delete();
    run_op('{4'd8, 32'h0000_0100, 32'hAABB_CCDD, 32'h0000_0055, 32'h0, 5, 32'h0000_0055, 1'b0},
           5'd3, 0, "sw100", c0);
    chk("sw100/nwrites", 32'(wlog.size()), 32'd4);
    for (int k = 0; k < 4 && k < wlog.size(); k++) begin
      chk($sformatf("sw100/a%0d", k), wlog[k].a, 32'h100 + 32'(k));
      chk($sformatf("sw100/d%0d", k), 32'(wlog[k].d), 32'(sw_bytes[k]));
      chk($sformatf("sw100/cyc%0d", k), wlog[k].cyc, c0 + 32'd1 + 32'(k));
    end

    // Load/store table.
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i], 5'(i + 1), 0, $sformatf("vec%0d", i), c0);
    end
    chk("wrap/m3fe", 32'(mem[10'h3FE]), 32'h44);
    chk("wrap/m3ff", 32'(mem[10'h3FF]), 32'h33);
    chk("wrap/m000", 32'(mem[10'h000]), 32'h22);
    chk("wrap/m001", 32'(mem[10'h001]), 32'h11);

    // DONE held by an external stall for three cycles.
    wlog.delete();
    run_op('{4'd1, 32'h0000_0200, 32'h0, 32'h0, 32'h0, 3, 32'hFFFF_FF80, 1'b1},
           5'd12, 3, "hold", c0);
    chk("hold/nwrites", 32'(wlog.size()), 32'd0);

    // Reset in c2 of a SW: only byte 0 reaches memory.
    wlog.delete();
    mem_op_i = 4'd8; mem_addr_i = 32'h0000_0180; mem_wdata_i = 32'h1122_3344;
    wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'h99; ram_if.mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst/req", 32'(ram_if.mem_req_o), 32'd0);
    chk("midrst/wr", 32'(ram_if.mem_wr_o), 32'd0);
    chk("midrst/a", ram_if.mem_a_o, 32'd0);
    chk("midrst/stall", 32'(stall_req_o), 32'd0);
    chk("midrst/wdata", wdata_o, 32'd0);
    chk("midrst/wd", 32'(wd_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_nop(5'd0, 1'b0, 32'h0);
    @(negedge clk);
    chk("midrst/idle_stall", 32'(stall_req_o), 32'd0);
    chk("midrst/idle_req", 32'(ram_if.mem_req_o), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst/nwrites", 32'(wlog.size()), 32'd1);
    chk("midrst/m180", 32'(mem[10'h180]), 32'h44);
    chk("midrst/m181", 32'(mem[10'h181]), 32'h00);
    chk("midrst/m183", 32'(mem[10'h183]), 32'h00);
    run_op('{4'd4, 32'h0000_0180, 32'h0, 32'h0, 32'h0, 3, 32'h0000_0044, 1'b1},
           5'd14, 0, "lbu_after_rst", c0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline. It sits directly downstream of the execute stage's EX/MEM register and upstream of MEM/WB.
- For non-memory instructions it passes the execute result through unchanged.
- For loads and stores it runs a byte-serial access on the shared 8-bit RAM port. It requests a pipeline stall until the access completes, then presents the assembled, sign- or zero-extended load data (or the pass-through result) to writeback.

Parameters:
- ADDR_W, 32, memory address width (wraps modulo 2^ADDR_W).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- wd_i  in  5  destination register address from EX/MEM.
- wreg_i  in  1  register write enable from EX/MEM.
- wdata_i  in  32  execute result from EX/MEM.
- mem_op_i  in  4  0=NOP, 1=LB, 2=LH, 3=LW, 4=LBU, 5=LHU, 6=SB, 7=SH, 8=SW; other codes are treated as NOP.
- mem_addr_i  in  ADDR_W  effective address, reg1+imm.
- mem_wdata_i  in  32  store data, taken from the low bytes.
- stall_i  in  1  stall from other pipeline sources; when high, EX/MEM holds.
- mem_gnt_i  in  1  RAM port granted this cycle by the IF/MEM arbiter.
- mem_din_i  in  8  RAM read data, valid the cycle after a read address was issued.
- mem_req_o  out  1  request for the RAM port.
- mem_a_o  out  ADDR_W  RAM byte address.
- mem_dout_o  out  8  RAM write data.
- mem_wr_o  out  1  RAM write strobe: 1=write, 0=read.
- wd_o  out  5  to MEM/WB.
- wreg_o  out  1  to MEM/WB.
- wdata_o  out  32  to MEM/WB.
- stall_req_o  out  1  stall request to the pipeline controller.

Behaviour:
- Access size N: 1 for B/BU, 2 for H/HU, 4 for W. Byte k goes to address mem_addr+k, little-endian. No misalignment check.
- States: IDLE, BUSY, LAST, DONE.
- Latched on leaving IDLE: op, addr, store data, wd, wreg, wdata. A byte counter cnt runs 0..N-1.
- IDLE:
  - mem_op_i = NOP: outputs = inputs combinationally, stall_req_o = 0.
  - mem_op_i is a memory op: stall_req_o = 1, wreg_o = 0, latch the inputs, cnt <= 0, next state BUSY.
- BUSY:
  - mem_req_o = 1 and stall_req_o = 1.
  - If mem_gnt_i = 1: drive mem_a_o = addr+cnt. For stores, mem_wr_o = 1 and mem_dout_o = data byte cnt. For loads, mem_wr_o = 0.
  - If mem_gnt_i = 0: mem_wr_o = 0 and cnt holds.
  - On a granted issue of byte N-1: stores go to DONE, loads go to LAST. Otherwise cnt increments on each granted issue.
- Read capture: any issued read sets rd_pending. On the next cycle, mem_din_i is captured into byte lane cnt_prev of the load buffer, regardless of gnt or state.
- LAST: mem_req_o = 0, stall_req_o = 1. Capture the final byte, then go to DONE.
- DONE:
  - stall_req_o = 0. wd_o and wreg_o come from the latched values.
  - wdata_o = loads: the buffer, sign-extended (LB/LH) or zero-extended (LBU/LHU); stores: the latched wdata with wreg_o forced 0.
  - Stays in DONE while stall_i = 1, so the held EX/MEM instruction is not re-executed. Goes to IDLE when stall_i = 0.
- Cycle latency from op at IDLE (c0) to DONE:
  - SB: c2. SH: c3. SW: c5.
  - LB: c3. LH: c4. LW: c6.
  - Each cycle with mem_gnt_i = 0 in BUSY adds one cycle.
- Outside BUSY, mem_wr_o = 0 and mem_a_o/mem_dout_o = 0.
- Reset:
  - State <= IDLE; cnt, rd_pending and buffers <= 0.
  - Registered outputs are 0, and mem_req_o, mem_wr_o, stall_req_o are 0 during reset.
  - Reset mid-access abandons the access; no further RAM writes are issued after the reset cycle.
- Address wrap: addr+k wraps modulo 2^ADDR_W, e.g. SW at 0xFFFFFFFE writes 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.

Test Plan:
- NOP/ALU op, wd=5, wreg=1, wdata=0x1234 -> same-cycle wd_o=5, wreg_o=1, wdata_o=0x1234, stall_req_o=0, mem_req_o=0.
- SW addr=0x100, data=0xAABBCCDD, gnt=1 -> writes DD@0x100, CC@0x101, BB@0x102, AA@0x103 on c1..c4; stall high c0..c4; DONE at c5 with wreg_o=0.
- RAM preloaded 0x80,0xFF at 0x200. Then:
  - LH -> DONE c4, wdata_o=0xFFFFFF80.
  - LHU -> wdata_o=0x0000FF80.
  - LB -> wdata_o=0xFFFFFF80.
- LW with gnt low on c2 and c3 -> bytes still land in the correct lanes and DONE moves from c6 to c8. The returned word equals memory contents.
- stall_i=1 during the DONE cycle for 3 cycles -> outputs stay stable, no re-issue (no mem_req_o), IDLE after stall_i falls.
- rst asserted at c2 of SW -> only byte 0 written, state IDLE, all outputs 0; a following LBU completes normally.
